reel_sequencer: RTL

REEL_SEQUENCER -- requirements
Module: reel_sequencer

---
 rtl/reel_sequencer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/reel_sequencer.sv
// Three-reel slot sequencer: credits, spin/stop/evaluate game flow, 0..9 reel digits.
// Latency: one edge per decision; EVAL result pulse one cycle after the final stop, busy drops the cycle after.
// No backpressure: single-cycle input pulses are acted on or ignored in the cycle they arrive.
module reel_sequencer #(
   parameter int unsigned TICK_DIV  = 5_000_000,
   parameter int unsigned AUTO_STOP = 150_000_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin_p,
   input  logic       start_p,
   input  logic       stop_p,
   output logic [3:0] reel0,
   output logic [3:0] reel1,
   output logic [3:0] reel2,
   output logic [2:0] spinning,
   output logic       busy,
   output logic [3:0] credits,
   output logic       pass_p,
   output logic       lose_p,
   output logic       err_p
);

   localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int TO_W   = (AUTO_STOP > 1) ? $clog2(AUTO_STOP) : 1;
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
   localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(AUTO_STOP - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SPIN0 = 3'd1,
      S_SPIN1 = 3'd2,
      S_SPIN2 = 3'd3,
      S_EVAL  = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic [2:0][3:0]     reel_q, reel_d;
   logic [2:0]          spin_q, spin_d;
   logic [3:0]          credits_q, credits_d;
   logic [TICK_W-1:0]   tick_q, tick_d;
   logic [TO_W-1:0]     to_q, to_d;
   logic                err_q, err_d;

   logic                busy_w;
   logic                start_ok;
   logic                tick_term;
   logic                in_spin;
   logic                stop_now;
   logic [1:0]          stop_idx;
   logic [2:0]          stop_mask;
   logic [2:0]          adv_mask;

   // Next-state, credit accounting, counters and reel advance decoded from registered state
   always_comb begin
      state_d   = state_q;
      reel_d    = reel_q;
      spin_d    = spin_q;
      credits_d = credits_q;
      tick_d    = '0;
      to_d      = '0;
      err_d     = 1'b0;
      stop_idx  = 2'd0;
      in_spin   = 1'b0;

      busy_w    = (state_q != S_IDLE);
      start_ok  = (state_q == S_IDLE) && start_p && (credits_q != 4'd0);
      tick_term = busy_w && (tick_q == TICK_LAST);

      case (state_q)
         S_SPIN0: begin in_spin = 1'b1; stop_idx = 2'd0; end
         S_SPIN1: begin in_spin = 1'b1; stop_idx = 2'd1; end
         S_SPIN2: begin in_spin = 1'b1; stop_idx = 2'd2; end
         default: begin in_spin = 1'b0; stop_idx = 2'd0; end
      endcase

      stop_now  = in_spin && (stop_p || (to_q == TO_LAST));
      stop_mask = stop_now ? (3'b001 << stop_idx) : 3'b000;
      // A reel being stopped this edge keeps its digit even on a tick.
      adv_mask  = tick_term ? (spin_q & ~stop_mask) : 3'b000;

      // A coin paired with an accepted start cancels the decrement.
      if (start_ok) begin
         if (!coin_p) credits_d = credits_q - 4'd1;
      end else if (coin_p && (credits_q != 4'd15)) begin
         credits_d = credits_q + 4'd1;
      end

      if (busy_w) tick_d = tick_term ? '0 : tick_q + 1'b1;
      if (in_spin) to_d = to_q + 1'b1;

      for (int k = 0; k < 3; k++) begin
         if (adv_mask[k]) reel_d[k] = (reel_q[k] == 4'd9) ? 4'd0 : reel_q[k] + 4'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (start_ok) begin
               state_d = S_SPIN0;
               spin_d  = 3'b111;
            end else if (start_p) begin
               err_d = 1'b1;
            end
         end
         S_SPIN0, S_SPIN1, S_SPIN2: begin
            if (stop_now) begin
               spin_d = spin_q & ~stop_mask;
               to_d   = '0;
               case (state_q)
                  S_SPIN0: state_d = S_SPIN1;
                  S_SPIN1: state_d = S_SPIN2;
                  default: state_d = S_EVAL;
               endcase
            end
         end
         S_EVAL:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // State and datapath registers; reset wins over every input
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         reel_q    <= '0;
         spin_q    <= '0;
         credits_q <= '0;
         tick_q    <= '0;
         to_q      <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         reel_q    <= reel_d;
         spin_q    <= spin_d;
         credits_q <= credits_d;
         tick_q    <= tick_d;
         to_q      <= to_d;
         err_q     <= err_d;
      end
   end

   assign reel0    = reel_q[0];
   assign reel1    = reel_q[1];
   assign reel2    = reel_q[2];
   assign spinning = spin_q;
   assign busy     = (state_q != S_IDLE);
   assign credits  = credits_q;
   assign err_p    = err_q;
   assign pass_p   = (state_q == S_EVAL) && (reel_q[0] == reel_q[1]) && (reel_q[1] == reel_q[2]);
   assign lose_p   = (state_q == S_EVAL) && !((reel_q[0] == reel_q[1]) && (reel_q[1] == reel_q[2]));

endmodule
